// File: rtl/mam_mem_sequencer_pkg.sv
// Shared types and constants for the MAM debug memory sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mam_seq_pkg;

    localparam int BEAT_BYTES = 2;
    localparam int BEATS_W    = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } seq_state_t;

    // Number of beats a request really moves: singles are one beat and a
    // zero-length burst is promoted to one beat so the sequencer never stalls.
    function automatic logic [BEATS_W-1:0] beats_eff(input logic burst,
                                                     input logic [BEATS_W-1:0] beats);
        if (!burst || beats == '0) begin
            return BEATS_W'(1);
        end
        return beats;
    endfunction

endpackage

// File: rtl/mam_mem_sequencer_if.sv
// Debug-side and memory-side bundles for the MAM memory sequencer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on request, write and read beats and memory commands.
interface mam_req_if
    import mam_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_rw;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic                      req_burst;
    logic [BEATS_W-1:0]        req_beats;
    logic                      write_valid;
    logic                      write_ready;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   write_strb;
    logic                      read_valid;
    logic                      read_ready;
    logic [DATA_WIDTH-1:0]     read_data;

    modport master (
        output req_valid, req_rw, req_addr, req_burst, req_beats,
               write_valid, write_data, write_strb, read_ready,
        input  req_ready, write_ready, read_valid, read_data
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_burst, req_beats,
               write_valid, write_data, write_strb, read_ready,
        output req_ready, write_ready, read_valid, read_data
    );
endinterface

interface mam_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb;
    logic                      mem_rsp_valid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mam_mem_sequencer_rd_fifo.sv
// Read-return FIFO, first-word fall-through, DEPTH a power of 2 (>= 2).
// Latency: push visible at pop_data the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module mam_seq_rd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = storage[rd_ptr];

    // Data array carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mam_mem_sequencer.sv
// Sequences MAM single/burst 16-bit beat requests onto a pipelined word memory port.
// Latency: writes pass through combinationally; first read beat 2 cycles + memory latency.
// Backpressure: read issue capped by outstanding limit and FIFO room; read_ready stalls only issue.
module mam_mem_sequencer
    import mam_seq_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RD_FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mam_req_if.slave    dbg,
    mam_mem_if.master   mem,
    output logic        busy,
    output logic        err_unexpected
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W  = $clog2(RD_FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_WRITE = WRITE;
    localparam logic [1:0] S_READ  = READ;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [STRB_W-1:0]     strb_q;
    logic [BEATS_W-1:0]    issue_left;
    logic [BEATS_W-1:0]    deliver_left;
    logic [OUT_W-1:0]      outstanding;

    logic                  in_idle;
    logic                  in_write;
    logic                  in_read;
    logic                  rd_issue_ok;
    logic                  cmd_fire;
    logic                  rsp_ok;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign in_idle  = (state == S_IDLE);
    assign in_write = (state == S_WRITE);
    assign in_read  = (state == S_READ);

    // A read may only go out if its response is guaranteed a FIFO slot.
    assign rd_issue_ok = in_read && (issue_left != '0)
                      && ((int'(outstanding) + int'(fifo_count)) < RD_FIFO_DEPTH)
                      && (int'(outstanding) < MAX_OUTSTANDING);

    assign dbg.req_ready   = in_idle;
    assign dbg.write_ready = in_write && mem.mem_req_ready;
    assign dbg.read_valid  = !fifo_empty;
    assign dbg.read_data   = fifo_empty ? '0 : fifo_head;

    assign mem.mem_req_valid = in_write ? dbg.write_valid : rd_issue_ok;
    assign mem.mem_we        = in_write;
    assign mem.mem_addr      = in_idle ? '0 : addr_q;
    assign mem.mem_wdata     = in_write ? dbg.write_data : '0;
    assign mem.mem_wstrb     = in_write ? strb_q : '0;

    assign busy      = !in_idle;
    assign cmd_fire  = mem.mem_req_valid && mem.mem_req_ready;
    // Responses with nothing outstanding are stray and never reach the FIFO.
    assign rsp_ok    = mem.mem_rsp_valid && (outstanding != '0);
    assign fifo_push = rsp_ok && !fifo_full;
    assign fifo_pop  = in_read && dbg.read_valid && dbg.read_ready;

    mam_seq_rd_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (mem.mem_rdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Request latch, per-beat address/count stepping and state transitions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            strb_q       <= '0;
            issue_left   <= '0;
            deliver_left <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dbg.req_valid) begin
                        addr_q       <= {dbg.req_addr[ADDR_WIDTH-1:1], 1'b0};
                        issue_left   <= beats_eff(dbg.req_burst, dbg.req_beats);
                        deliver_left <= beats_eff(dbg.req_burst, dbg.req_beats);
                        strb_q       <= dbg.req_burst ? '1 : dbg.write_strb;
                        state        <= dbg.req_rw ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (cmd_fire) begin
                        addr_q     <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
                        issue_left <= issue_left - BEATS_W'(1);
                        if (issue_left == BEATS_W'(1)) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_READ: begin
                    if (cmd_fire) begin
                        addr_q     <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
                        issue_left <= issue_left - BEATS_W'(1);
                    end
                    if (fifo_pop) begin
                        deliver_left <= deliver_left - BEATS_W'(1);
                        if (deliver_left == BEATS_W'(1)) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reads in flight at the memory; issue and return in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({cmd_fire && in_read, rsp_ok})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky flag for responses that no command asked for.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_unexpected <= 1'b0;
        end else if (mem.mem_rsp_valid && (outstanding == '0)) begin
            err_unexpected <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mam_mem_sequencer.sv
// Directed bench for mam_mem_sequencer: vector table plus reset/error sequences.
// Memory model answers reads after a fixed latency with address-derived data.
// Inputs change on the falling edge; outputs are sampled 1-2 ns later.
module tb_mam_mem_sequencer;
    import mam_seq_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic err_unexpected;

    always #5 clk = ~clk;

    mam_req_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbg ();
    mam_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

    mam_mem_sequencer #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (4),
        .RD_FIFO_DEPTH   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dbg            (dbg),
        .mem            (mem),
        .busy           (busy),
        .err_unexpected (err_unexpected)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic        burst;
        logic [13:0] beats;
        logic [1:0]  strb;
        logic        toggle;
        int          hold;
        logic [15:0] wd0;
        int          exp_n;
        logic [1:0]  exp_strb;
    } vec_t;

    vec_t vecs [8];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic        pipe_vld [8];
    logic [15:0] pipe_dat [8];
    int          tb_out;
    int          max_out;

    logic [31:0] c_addr  [$];
    logic        c_we    [$];
    logic [15:0] c_wdata [$];
    logic [1:0]  c_wstrb [$];
    logic [15:0] r_data  [$];
    int          last_cmd_cyc;
    int          last_pop_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mdata(input logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'hA5C3;
    endfunction

    task automatic clear_pipe();
        for (int i = 0; i < 8; i++) begin
            pipe_vld[i] = 1'b0;
            pipe_dat[i] = '0;
        end
        tb_out = 0;
        mem.mem_rsp_valid = 1'b0;
        mem.mem_rdata = '0;
    endtask

    // Called on a falling edge with inputs set: records handshakes, crosses one
    // rising edge, then drives the memory response for the new cycle.
    task automatic tick();
        #1;
        if (mem.mem_req_valid && mem.mem_req_ready) begin
            c_addr.push_back(mem.mem_addr);
            c_we.push_back(mem.mem_we);
            c_wdata.push_back(mem.mem_wdata);
            c_wstrb.push_back(mem.mem_wstrb);
            last_cmd_cyc = cyc;
            if (!mem.mem_we) begin
                pipe_vld[LAT-1] = 1'b1;
                pipe_dat[LAT-1] = mdata(mem.mem_addr);
                tb_out++;
                if (tb_out > max_out) max_out = tb_out;
            end
        end
        if (dbg.read_valid && dbg.read_ready) begin
            r_data.push_back(dbg.read_data);
            last_pop_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        mem.mem_rsp_valid = pipe_vld[0];
        mem.mem_rdata     = pipe_dat[0];
        if (pipe_vld[0]) tb_out--;
        for (int i = 0; i < 7; i++) begin
            pipe_vld[i] = pipe_vld[i+1];
            pipe_dat[i] = pipe_dat[i+1];
        end
        pipe_vld[7] = 1'b0;
    endtask

    task automatic idle_inputs();
        dbg.req_valid   = 1'b0;
        dbg.req_rw      = 1'b0;
        dbg.req_addr    = '0;
        dbg.req_burst   = 1'b0;
        dbg.req_beats   = '0;
        dbg.write_valid = 1'b0;
        dbg.write_data  = '0;
        dbg.write_strb  = '0;
        dbg.read_ready  = 1'b0;
        mem.mem_req_ready = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        clear_pipe();
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        c_addr.delete();
        c_we.delete();
        c_wdata.delete();
        c_wstrb.delete();
        r_data.delete();
        max_out      = 0;
        last_cmd_cyc = -1;
        last_pop_cyc = -1;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        logic [31:0] base;
        int          busy_low;
        int          rel_cmds;
        string       tag;
        tag      = $sformatf("v%0d", idx);
        base     = {v.addr[31:1], 1'b0};
        busy_low = -1;
        rel_cmds = -1;
        clear_log();
        dbg.req_valid  = 1'b1;
        dbg.req_rw     = v.rw;
        dbg.req_addr   = v.addr;
        dbg.req_burst  = v.burst;
        dbg.req_beats  = v.beats;
        dbg.write_strb = v.strb;
        #1;
        check({tag, "_req_ready"}, 32'(dbg.req_ready), 32'd1);
        tick();
        dbg.req_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            dbg.write_valid   = v.rw;
            dbg.write_data    = v.wd0 + 16'(c_addr.size());
            mem.mem_req_ready = v.toggle ? (k % 2 == 0) : 1'b1;
            dbg.read_ready    = (k >= v.hold);
            if (k == v.hold) rel_cmds = c_addr.size();
            #1;
            if (!busy) begin
                busy_low = cyc;
                break;
            end
            tick();
        end
        dbg.write_valid   = 1'b0;
        dbg.read_ready    = 1'b0;
        mem.mem_req_ready = 1'b1;
        if (busy_low < 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end
        check({tag, "_cmd_count"}, 32'(c_addr.size()), 32'(v.exp_n));
        for (int i = 0; i < c_addr.size() && i < v.exp_n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), c_addr[i], base + 32'(2 * i));
            check($sformatf("%s_we%0d", tag, i), 32'(c_we[i]), 32'(v.rw));
            if (v.rw) begin
                check($sformatf("%s_wstrb%0d", tag, i), 32'(c_wstrb[i]), 32'(v.exp_strb));
                check($sformatf("%s_wdata%0d", tag, i), 32'(c_wdata[i]), 32'(v.wd0 + 16'(i)));
            end
        end
        if (v.rw) begin
            check({tag, "_busy_drop"}, 32'(busy_low), 32'(last_cmd_cyc + 1));
        end else begin
            check({tag, "_rd_count"}, 32'(r_data.size()), 32'(v.exp_n));
            for (int i = 0; i < r_data.size() && i < v.exp_n; i++) begin
                check($sformatf("%s_rdata%0d", tag, i), 32'(r_data[i]), 32'(mdata(base + 32'(2 * i))));
            end
            check({tag, "_busy_drop"}, 32'(busy_low), 32'(last_pop_cyc + 1));
            check({tag, "_max_out_le4"}, 32'(max_out <= 4), 32'd1);
            if (v.hold > 0) begin
                check({tag, "_issued_at_release"}, 32'(rel_cmds), 32'd4);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rw    addr          burst beats   strb  tgl  hold wd0       n  exp_strb
        vecs[0] = '{1'b1, 32'h80000001, 1'b0, 14'd0, 2'b10, 1'b0, 0, 16'hBEEF, 1, 2'b10};
        vecs[1] = '{1'b0, 32'h00020000, 1'b1, 14'd8, 2'b00, 1'b0, 0, 16'h0000, 8, 2'b00};
        vecs[2] = '{1'b0, 32'h00001000, 1'b1, 14'd6, 2'b00, 1'b0, 20, 16'h0000, 6, 2'b00};
        vecs[3] = '{1'b1, 32'hFFFFFFFC, 1'b1, 14'd4, 2'b01, 1'b1, 0, 16'h1111, 4, 2'b11};
        vecs[4] = '{1'b0, 32'h00000300, 1'b1, 14'd0, 2'b00, 1'b0, 0, 16'h0000, 1, 2'b00};
        vecs[5] = '{1'b1, 32'h00000010, 1'b1, 14'd0, 2'b00, 1'b0, 0, 16'h2222, 1, 2'b11};
        vecs[6] = '{1'b0, 32'h00000041, 1'b0, 14'd5, 2'b00, 1'b0, 0, 16'h0000, 1, 2'b00};
        vecs[7] = '{1'b1, 32'h00000021, 1'b0, 14'd9, 2'b01, 1'b0, 0, 16'h3333, 1, 2'b01};

        clear_pipe();
        clear_log();
        do_reset(2);

        // Reset state, with write-side inputs active to show IDLE ignores them.
        dbg.write_valid = 1'b1;
        dbg.write_data  = 16'h1234;
        dbg.write_strb  = 2'b11;
        #1;
        check("rst_req_ready",     32'(dbg.req_ready),     32'd1);
        check("rst_busy",          32'(busy),              32'd0);
        check("rst_mem_req_valid", 32'(mem.mem_req_valid), 32'd0);
        check("rst_write_ready",   32'(dbg.write_ready),   32'd0);
        check("rst_read_valid",    32'(dbg.read_valid),    32'd0);
        check("rst_read_data",     32'(dbg.read_data),     32'd0);
        check("rst_mem_we",        32'(mem.mem_we),        32'd0);
        check("rst_mem_addr",      mem.mem_addr,           32'd0);
        check("rst_mem_wdata",     32'(mem.mem_wdata),     32'd0);
        check("rst_mem_wstrb",     32'(mem.mem_wstrb),     32'd0);
        check("rst_err",           32'(err_unexpected),    32'd0);
        tick();
        idle_inputs();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], i);
            tick();
        end
        #1;
        check("err_after_table", 32'(err_unexpected), 32'd0);
        tick();

        // Reset in the middle of an 8-beat read after three beats delivered.
        clear_log();
        dbg.req_valid = 1'b1;
        dbg.req_rw    = 1'b0;
        dbg.req_addr  = 32'h00005000;
        dbg.req_burst = 1'b1;
        dbg.req_beats = 14'd8;
        tick();
        dbg.req_valid  = 1'b0;
        dbg.read_ready = 1'b1;
        for (int k = 0; k < 100 && r_data.size() < 3; k++) tick();
        check("mid_rst_three_beats", 32'(r_data.size()), 32'd3);
        do_reset(1);
        #1;
        check("mid_rst_req_ready",     32'(dbg.req_ready),     32'd1);
        check("mid_rst_busy",          32'(busy),              32'd0);
        check("mid_rst_read_valid",    32'(dbg.read_valid),    32'd0);
        check("mid_rst_mem_req_valid", 32'(mem.mem_req_valid), 32'd0);
        tick();
        run_txn(vecs[6], 16);
        tick();
        #1;
        check("mid_rst_no_err", 32'(err_unexpected), 32'd0);
        tick();

        // Stray response in IDLE: flag sets, data dropped, flag sticks until reset.
        mem.mem_rsp_valid = 1'b1;
        mem.mem_rdata     = 16'hDEAD;
        tick();
        #1;
        check("err_set",          32'(err_unexpected), 32'd1);
        check("err_no_read_data", 32'(dbg.read_valid), 32'd0);
        tick();
        run_txn(vecs[0], 20);
        tick();
        #1;
        check("err_sticky", 32'(err_unexpected), 32'd1);
        tick();
        do_reset(1);
        #1;
        check("err_cleared", 32'(err_unexpected), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
